radix_pack_converter: RTL

Parametrised IEEE-754 down-converter and lane packer for the SpMV result path. It accepts a stream of 64-bit doubles and converts each to double, single or half precision, selected per packet, using in-house round-to-nearest-even logic. Results are packed densely into OUT_W-bit output words with byte keeps, and sticky exception flags are raised. It sits between the SpMV accumulator output and the host write-back DMA, replacing the vendor conversion IP chain.

---
 rtl/spmv_fp_pkg.sv | 33 +++
 rtl/fp_down_round.sv | 88 ++++++++
 rtl/radix_pack_converter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spmv_fp_pkg.sv
// rtl/spmv_fp_pkg.sv - shared IEEE-754 format constants for the SpMV result path
package spmv_fp_pkg;

  typedef enum logic [1:0] {
    MODE_HALF   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_DOUBLE = 2'd2
  } fp_mode_e;

  localparam int D_BIAS = 1023;
  localparam int S_BIAS = 127;
  localparam int H_BIAS = 15;

  localparam int S_EMAX = 254;
  localparam int H_EMAX = 30;

  localparam int D_MANT = 52;
  localparam int S_MANT = 23;
  localparam int H_MANT = 10;

  localparam logic [31:0] S_QNAN = 32'h7FC0_0000;
  localparam logic [15:0] H_QNAN = 16'h7E00;

  // The unused encoding 3 behaves as double.
  function automatic fp_mode_e norm_mode(input logic [1:0] c);
    case (c)
      2'd0:    return MODE_HALF;
      2'd1:    return MODE_SINGLE;
      default: return MODE_DOUBLE;
    endcase
  endfunction

endpackage

// File: rtl/fp_down_round.sv
// rtl/fp_down_round.sv - combinational double to single/half RNE down-converter
module fp_down_round
  import spmv_fp_pkg::*;
(
  input  logic [63:0] din,
  input  fp_mode_e    mode,
  output logic [63:0] dout,
  output logic        ovf,
  output logic        unf,
  output logic        nan
);

  logic                sgn;
  logic [10:0]         bexp;
  logic [D_MANT-1:0]   man;
  logic                s_rnd;
  logic                h_rnd;
  logic [S_MANT:0]     s_mr;
  logic [H_MANT:0]     h_mr;
  logic signed [12:0]  s_e;
  logic signed [12:0]  h_e;

  // Round both narrow formats straight from the 53-bit significand, then pick by mode.
  always_comb begin
    dout  = '0;
    ovf   = 1'b0;
    unf   = 1'b0;
    nan   = 1'b0;
    sgn   = din[63];
    bexp  = din[62:52];
    man   = din[51:0];

    // guard & (sticky | lsb): round half to even
    s_rnd = man[D_MANT-1-S_MANT] & ((|man[D_MANT-2-S_MANT:0]) | man[D_MANT-S_MANT]);
    h_rnd = man[D_MANT-1-H_MANT] & ((|man[D_MANT-2-H_MANT:0]) | man[D_MANT-H_MANT]);
    s_mr  = {1'b0, man[D_MANT-1 -: S_MANT]} + {{S_MANT{1'b0}}, s_rnd};
    h_mr  = {1'b0, man[D_MANT-1 -: H_MANT]} + {{H_MANT{1'b0}}, h_rnd};

    // A mantissa carry out bumps the exponent; the mantissa field is then zero.
    s_e = 13'({2'b00, bexp}) - 13'(D_BIAS - S_BIAS) + 13'(s_mr[S_MANT]);
    h_e = 13'({2'b00, bexp}) - 13'(D_BIAS - H_BIAS) + 13'(h_mr[H_MANT]);

    if (mode == MODE_DOUBLE) begin
      dout = din;
    end else if (mode == MODE_SINGLE) begin
      if (bexp == 11'h7FF) begin
        if (man != '0) begin
          nan  = 1'b1;
          dout = {32'b0, sgn, S_QNAN[30:0]};
        end else begin
          dout = {32'b0, sgn, 8'hFF, 23'b0};
        end
      end else if (bexp == 11'h000) begin
        unf  = (man != '0);
        dout = {32'b0, sgn, 31'b0};
      end else if (s_e <= 0) begin
        unf  = 1'b1;
        dout = {32'b0, sgn, 31'b0};
      end else if (s_e > S_EMAX) begin
        ovf  = 1'b1;
        dout = {32'b0, sgn, 8'hFF, 23'b0};
      end else begin
        dout = {32'b0, sgn, s_e[7:0], s_mr[S_MANT-1:0]};
      end
    end else begin
      if (bexp == 11'h7FF) begin
        if (man != '0) begin
          nan  = 1'b1;
          dout = {48'b0, sgn, H_QNAN[14:0]};
        end else begin
          dout = {48'b0, sgn, 5'h1F, 10'b0};
        end
      end else if (bexp == 11'h000) begin
        unf  = (man != '0);
        dout = {48'b0, sgn, 15'b0};
      end else if (h_e <= 0) begin
        unf  = 1'b1;
        dout = {48'b0, sgn, 15'b0};
      end else if (h_e > H_EMAX) begin
        ovf  = 1'b1;
        dout = {48'b0, sgn, 5'h1F, 10'b0};
      end else begin
        dout = {48'b0, sgn, h_e[4:0], h_mr[H_MANT-1:0]};
      end
    end
  end

endmodule

// File: rtl/radix_pack_converter.sv
// rtl/radix_pack_converter.sv - double down-converter and dense lane packer with skid output
module radix_pack_converter
  import spmv_fp_pkg::*;
#(
  parameter int OUT_W = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         Ctrl_sig,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [OUT_W/8-1:0] out_keep,
  output logic               out_last,
  output logic               flag_ovf,
  output logic               flag_unf,
  output logic               flag_nan,
  input  logic               flag_clr
);

  localparam int LANES_D = OUT_W / 64;
  localparam int LANES_S = OUT_W / 32;
  localparam int LANES_H = OUT_W / 16;
  localparam int KEEP_W  = OUT_W / 8;
  localparam int LW      = $clog2(LANES_H) + 1;

  logic             rdy_en;
  logic             pkt_open;
  fp_mode_e         cur_mode;
  fp_mode_e         beat_mode;
  logic             accept;

  logic [63:0]      c_data;
  logic             c_ovf;
  logic             c_unf;
  logic             c_nan;

  logic             s1_valid;
  logic [63:0]      s1_data;
  logic             s1_last;
  fp_mode_e         s1_mode;

  logic [OUT_W-1:0] pack_data;
  logic [LW-1:0]    pack_lane;

  logic [LW-1:0]    lanes_n;
  int               lane_bits;
  int               lane_bytes;
  int               fill_bytes;
  logic [OUT_W-1:0] word_next;
  logic [KEEP_W-1:0] keep_next;
  logic             word_done;
  logic             s1_adv;
  logic             push;
  logic             pop;

  logic [OUT_W-1:0]  q_data [2];
  logic [KEEP_W-1:0] q_keep [2];
  logic              q_last [2];
  logic              q_rd;
  logic              q_wr;
  logic [1:0]        q_cnt;

  assign accept    = in_valid & in_ready;
  assign beat_mode = pkt_open ? cur_mode : norm_mode(Ctrl_sig);

  fp_down_round u_round (
    .din  (in_data),
    .mode (beat_mode),
    .dout (c_data),
    .ovf  (c_ovf),
    .unf  (c_unf),
    .nan  (c_nan)
  );

  // Merge the stage-1 result into the pack register and decide whether a word closes.
  always_comb begin
    lanes_n    = LW'(LANES_D);
    lane_bits  = 64;
    lane_bytes = 8;
    case (s1_mode)
      MODE_HALF: begin
        lanes_n    = LW'(LANES_H);
        lane_bits  = 16;
        lane_bytes = 2;
      end
      MODE_SINGLE: begin
        lanes_n    = LW'(LANES_S);
        lane_bits  = 32;
        lane_bytes = 4;
      end
      default: begin
        lanes_n    = LW'(LANES_D);
        lane_bits  = 64;
        lane_bytes = 8;
      end
    endcase
    word_next  = pack_data | (OUT_W'(s1_data) << (int'(pack_lane) * lane_bits));
    fill_bytes = (int'(pack_lane) + 1) * lane_bytes;
    keep_next  = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      keep_next[b] = (b < fill_bytes);
    end
    word_done = (pack_lane == lanes_n - LW'(1)) | s1_last;
    // A closing beat waits only when both skid entries are occupied.
    s1_adv    = s1_valid & (~word_done | (q_cnt != 2'd2));
    push      = s1_adv & word_done;
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = (q_cnt != 2'd0);
  assign out_data  = out_valid ? q_data[q_rd] : '0;
  assign out_keep  = out_valid ? q_keep[q_rd] : '0;
  assign out_last  = out_valid ? q_last[q_rd] : 1'b0;
  // Only registered state feeds in_ready; out_ready never reaches it.
  assign in_ready  = rdy_en & (~s1_valid | s1_adv);

  // Hold in_ready low through reset and for the first edge after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Latch the mode on the opening beat of a packet; hold it until in_last is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_open <= 1'b0;
      cur_mode <= MODE_HALF;
    end else if (accept) begin
      pkt_open <= ~in_last;
      cur_mode <= beat_mode;
    end
  end

  // Stage-1 register: converted beat plus its packet position and mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_HALF;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= c_data;
      s1_last  <= in_last;
      s1_mode  <= beat_mode;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Pack register: accumulate lanes, restart at lane 0 once a word leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_data <= '0;
      pack_lane <= '0;
    end else if (s1_adv) begin
      if (word_done) begin
        pack_data <= '0;
        pack_lane <= '0;
      end else begin
        pack_data <= word_next;
        pack_lane <= pack_lane + LW'(1);
      end
    end
  end

  // Two-entry skid FIFO holding finished words; the head is what the port shows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_keep[i] <= '0;
        q_last[i] <= 1'b0;
      end
      q_rd  <= 1'b0;
      q_wr  <= 1'b0;
      q_cnt <= 2'd0;
    end else begin
      if (push) begin
        q_data[q_wr] <= word_next;
        q_keep[q_wr] <= keep_next;
        q_last[q_wr] <= s1_last;
        q_wr         <= ~q_wr;
      end
      if (pop) begin
        q_rd <= ~q_rd;
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Sticky exception flags; an event in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_nan <= 1'b0;
    end else begin
      flag_ovf <= (accept & c_ovf) | (flag_ovf & ~flag_clr);
      flag_unf <= (accept & c_unf) | (flag_unf & ~flag_clr);
      flag_nan <= (accept & c_nan) | (flag_nan & ~flag_clr);
    end
  end

endmodule
